// File: rtl/imem_loader.sv
// imem_loader: instruction memory whose fetch port reads like the block ROM, plus a byte-serial,
// big-endian program-load port that stalls the CPU while loading. Optional macro: IMEM_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addra,
  output logic [31:0]       douta,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_hold,
  output logic              ld_err,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd5;
`ifdef IMEM_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_POST = S_CHK;
`else
  localparam logic [2:0] S_POST = S_DONE;
`endif

  logic [2:0]        state;
  logic [15:0]       len;
  logic [23:0]       hold;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       word_cnt;
  logic              accept;
  logic              mem_we;
  logic [31:0]       mem [0:DEPTH-1];

  // Handshake: a byte transfers on a rising edge where ld_valid & ld_ready; ld_ready is decoded
  // from the state register only, so it never depends on ld_valid and a byte offered while
  // ld_ready is low is simply dropped.
  assign ld_ready  = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA)
`ifdef IMEM_CHECKSUM_EN
                     || (state == S_CHK)
`endif
                     ;
  assign accept    = ld_valid & ld_ready;
  assign ld_busy   = (state != S_IDLE);
  assign cpu_hold  = ld_busy;
  assign ld_done   = (state == S_DONE);
  assign dbg_state = state;
  assign mem_we    = !reset && accept && (state == S_DATA) && (phase == 2'd3);

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign ld_err = err_q;
`else
  assign ld_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      hold     <= '0;
      phase    <= '0;
      wr_addr  <= '0;
      word_cnt <= '0;
      ld_count <= '0;
`ifdef IMEM_CHECKSUM_EN
      csum     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            state    <= S_HDR0;
            phase    <= '0;
            wr_addr  <= '0;
            word_cnt <= '0;
            ld_count <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end
        S_HDR0: begin
          if (accept) begin
            len[15:8] <= ld_byte;
            state     <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            len[7:0] <= ld_byte;
            state    <= ({len[15:8], ld_byte} == 16'd0) ? S_POST : S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            phase <= phase + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            csum  <= csum ^ ld_byte;
`endif
            if (phase != 2'd3) begin
              hold <= {hold[15:0], ld_byte};
            end else begin
              // wr_addr wraps with the memory; ld_count only saturates at the depth.
              wr_addr  <= wr_addr + ADDR_W'(1);
              word_cnt <= word_cnt + 16'd1;
              if (ld_count != COUNT_MAX) ld_count <= ld_count + (ADDR_W+1)'(1);
              if (word_cnt + 16'd1 == len) state <= S_POST;
            end
          end
        end
`ifdef IMEM_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            err_q <= (ld_byte != csum);
            state <= S_DONE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write and read share one edge; the read sees the pre-write word (read-first).
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_addr] <= {hold, ld_byte};
  end

  always_ff @(posedge clock) begin
    if (reset) douta <= '0;
    else       douta <= mem[addra];
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions from the test plan plus randomized
// loads, checked against a word-level memory model; honours IMEM_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addra = '0;
  logic [31:0]       douta;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_byte = '0;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;
  logic              cpu_hold;
  logic              ld_err;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .addra(addra), .douta(douta),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_count(ld_count), .cpu_hold(cpu_hold), .ld_err(ld_err),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [int];
  logic [31:0] exp_q[$];
  logic [31:0] ld_words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited = 0;
    if (gap) begin
      ld_valid = 1'b0;
      ld_byte  = 8'($urandom);
      tick();
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    while (!ld_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!ld_ready) check("ready_timeout", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic rd_check(input int a, input string tag);
    exp_q.push_back(model_mem[a]);
    addra = ADDR_W'(a);
    tick();
    check(tag, douta, exp_q.pop_front());
  endtask

  // One load session from ld_words; abort_at >= 0 resets after that many data bytes.
  task automatic load(input int len, input bit gaps, input bit glitch, input int abort_at,
                      input bit bad_csum);
    logic [7:0]  csum = 8'h00;
    logic [7:0]  b;
    int          last;
    bit          rf_known;
    logic [31:0] rf_old = '0;
    bit          exp_err;
    last     = (len > 0) ? (len - 1) % DEPTH : 0;
    rf_known = (len > 0) && (abort_at < 0) && model_mem.exists(last);
    if (rf_known) rf_old = model_mem[last];
    exp_err  = CSUM_EN && bad_csum;
    addra    = ADDR_W'(last);

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("busy_rise",   32'(ld_busy),  32'd1);
    check("hold_rise",   32'(cpu_hold), 32'd1);
    check("ready_hdr",   32'(ld_ready), 32'd1);
    check("count_clear", 32'(ld_count), 32'd0);
    check("err_clear",   32'(ld_err),   32'd0);

    send_byte(8'(len >> 8), gaps);
    send_byte(8'(len), gaps);
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'(ld_words[i / 4] >> (8 * (3 - i % 4)));
      if (glitch && i == 5) ld_start = 1'b1;
      send_byte(b, gaps);
      ld_start = 1'b0;
      csum ^= b;
      if (i % 4 == 3) model_mem[(i / 4) % DEPTH] = ld_words[i / 4];
      if (i + 1 == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",  32'(ld_busy),  32'd0);
        check("abort_hold",  32'(cpu_hold), 32'd0);
        check("abort_ready", 32'(ld_ready), 32'd0);
        check("abort_count", 32'(ld_count), 32'd0);
        check("abort_done",  32'(ld_done),  32'd0);
        return;
      end
      if (i == 4 * len - 1 && rf_known) check("read_first", douta, rf_old);
    end
    if (CSUM_EN) send_byte(bad_csum ? (csum ^ 8'h01) : csum, gaps);

    check("done_pulse", 32'(ld_done),  32'd1);
    check("busy_at_done", 32'(ld_busy), 32'd1);
    check("count_final", 32'(ld_count), 32'((len > DEPTH) ? DEPTH : len));
    check("err_flag",   32'(ld_err),   32'(exp_err));
    tick();
    check("done_low",   32'(ld_done),  32'd0);
    check("busy_fall",  32'(ld_busy),  32'd0);
    check("hold_fall",  32'(cpu_hold), 32'd0);
    check("err_sticky", 32'(ld_err),   32'(exp_err));
    if (len > 0) check("wr_visible", douta, ld_words[len - 1]);
  endtask

  task automatic idle_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    check("idle_ready", 32'(ld_ready), 32'd0);
    check("idle_busy",  32'(ld_busy),  32'd0);
  endtask

  initial begin
    int len;
    int maxlen = 0;

    // reset
    reset = 1'b1;
    repeat (3) tick();
    check("rst_douta", douta,          32'd0);
    check("rst_ready", 32'(ld_ready),  32'd0);
    check("rst_busy",  32'(ld_busy),   32'd0);
    check("rst_done",  32'(ld_done),   32'd0);
    check("rst_count", 32'(ld_count),  32'd0);
    check("rst_hold",  32'(cpu_hold),  32'd0);
    check("rst_err",   32'(ld_err),    32'd0);
    reset = 1'b0;
    tick();
    idle_pulses(4);

    // directed two-word program at one byte per cycle
    ld_words = '{32'h24080005, 32'h3C011234};
    load(2, 1'b0, 1'b0, -1, 1'b0);
    rd_check(1, "rd_word1");
    rd_check(0, "rd_word0");
    idle_pulses(5);
    check("idle_count", 32'(ld_count), 32'd2);
    rd_check(0, "idle_nowr0");
    rd_check(1, "idle_nowr1");

    // same program with toggling valid and a stray ld_start mid-DATA
    load(2, 1'b1, 1'b1, -1, 1'b0);
    rd_check(0, "gap_word0");
    rd_check(1, "gap_word1");

    // empty program
    ld_words = '{};
    load(0, 1'b0, 1'b0, -1, 1'b0);
    rd_check(0, "len0_word0");

    // reset after 6 data bytes: word 0 lands, word 1 keeps its old value
    ld_words = '{32'hA5A50001, 32'hB6B60002};
    load(2, 1'b0, 1'b0, 6, 1'b0);
    rd_check(0, "abort_word0");
    rd_check(1, "abort_word1");

`ifdef IMEM_CHECKSUM_EN
    ld_words = '{32'h11223344};
    load(1, 1'b0, 1'b0, -1, 1'b0);
    ld_words = '{32'h11223344};
    load(1, 1'b0, 1'b0, -1, 1'b1);
    rd_check(0, "csum_bad_word0");
`endif

    // randomized sessions
    for (int s = 0; s < 10; s++) begin
      len = $urandom_range(1, 6);
      if (len > maxlen) maxlen = len;
      ld_words = '{};
      for (int w = 0; w < len; w++) ld_words.push_back($urandom);
      load(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
           1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) rd_check($urandom_range(0, maxlen - 1), "rand_rd");
    end
    for (int a = 0; a < maxlen; a++) rd_check(a, "final_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a byte-serial program-load port. It is the write side of the instruction ROM that the fetch unit reads.
- A host (UART bridge or testbench) streams a length header and big-endian instruction bytes.
- The block assembles the bytes into 32-bit words, writes them at word addresses 0, 1, 2, …, and holds the CPU while loading.
- The fetch unit keeps reading through `addra`/`douta` exactly as from the block ROM.

## Interface
- `ADDR_W`, 14: word-address width; depth is 2^ADDR_W words (64 KB).
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `addra`  in  ADDR_W: fetch word address, driven from PC[15:2].
- `douta`  out  32: instruction at `addra`, registered.
- `ld_start`  in  1: request a load session.
- `ld_valid`  in  1: `ld_byte` is valid.
- `ld_byte`  in  8: load stream byte.
- `ld_ready`  out  1: block accepts a byte this cycle.
- `ld_busy`  out  1: load session in progress.
- `ld_done`  out  1: one-cycle pulse at end of session.
- `ld_count`  out  ADDR_W+1: number of words written in the current or last session.
- `cpu_hold`  out  1: stall request to the CPU; equals `ld_busy`.
- `ld_err`  out  1: checksum mismatch, sticky until the next `ld_start` (see Configuration).

## Operation
- A byte is accepted on any rising edge where `ld_valid & ld_ready`.
- States: IDLE, HDR0, HDR1, DATA, [CHK], DONE.
- IDLE: `ld_ready`=0. `ld_start`=1 → HDR0. This clears `ld_count`, the write address, the byte phase and `ld_err`.
- HDR0: accept byte → `len[15:8]`, then → HDR1.
- HDR1: accept byte → `len[7:0]`.
  - If len=0: → DONE, or CHK when the checksum feature is compiled in.
  - Otherwise → DATA.
- DATA: bytes are taken MSB-first.
  - Phases 0–2 shift the byte into a 24-bit holding register.
  - Phase 3 writes {hold, byte} to mem[wr_addr] on the same edge, then increments wr_addr and `ld_count`.
  - After the word numbered len is written: → DONE, or CHK.
- DONE: `ld_done`=1 for exactly one cycle, then → IDLE.
- `ld_start` outside IDLE is ignored.
- `ld_valid` while `ld_ready`=0 is ignored; the byte is dropped.
- Address wrap: wr_addr is ADDR_W bits and wraps modulo 2^ADDR_W.
  - A len greater than the depth overwrites from word 0.
  - `ld_count` still counts up to len, saturating at 2^ADDR_W.
- Fetch read: `douta` ← mem[`addra`] every cycle, regardless of state.
- Same-cycle write and read of one address is read-first: `douta` shows the old word.
- Reset mid-session:
  - → IDLE, and all outputs return to reset values.
  - Memory contents are retained; a partially assembled word is discarded.

## Timing
- Reset values: `douta`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `ld_count`=0, `cpu_hold`=0, `ld_err`=0.
- Fetch latency: 1 cycle, from `addra` at edge N to `douta` valid after edge N+1.
- `ld_ready`=1 in HDR0, HDR1, DATA and CHK. It is a registered, state-decoded output, so it never depends combinationally on `ld_valid`.
- Maximum throughput: one byte per cycle.
- `ld_busy`/`cpu_hold` rise on the edge that leaves IDLE and fall on the edge that leaves DONE.
- A written word is visible on `douta` two edges after its final byte is accepted: one edge to write, one to read.
- `ld_done` is high in the cycle after the final accepted byte.
- Minimum session length: 2 header bytes + 4·len data bytes (+1 checksum byte) + 2 cycles.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - The CHK state is present and takes one trailing byte.
  - The checksum is the XOR of all data bytes; header bytes are excluded.
  - On a mismatch, `ld_err`=1 from the CHK accept edge until the next `ld_start`.
  - Words already written are not rolled back.
- `IMEM_CHECKSUM_EN` undefined:
  - No CHK state; HDR1 (len=0) or the final DATA byte goes directly to DONE.
  - `ld_err` is tied to 0.

## Test plan
- Reset, then hold `addra`=0 → `douta`=0, `ld_ready`=0, `cpu_hold`=0. Any `ld_valid` pulses produce no write.
- `ld_start`, header 00 02, bytes 24 08 00 05 3C 01 12 34 at 1 byte/cycle → mem[0]=0x24080005, mem[1]=0x3C011234, `ld_count`=2, a single `ld_done` pulse, `cpu_hold` low afterwards. Reading `addra`=1 gives 0x3C011234 one cycle later.
- Same load with `ld_valid` toggling every other cycle, and `ld_start` re-asserted mid-DATA → identical memory contents; the `ld_start` has no effect.
- Header 00 00 → no write, `ld_count`=0, `ld_done` pulses 1 cycle after the second header byte (after the CHK byte 00 when `IMEM_CHECKSUM_EN` is defined).
- `reset` after 6 data bytes of a len=2 load → IDLE, mem[0] keeps the new word, mem[1] is unchanged, `ld_count`=0.
- `IMEM_CHECKSUM_EN`: len=1, bytes 11 22 33 44, checksum 44 → `ld_err`=0. Checksum 45 → `ld_err`=1 and mem[0]=0x11223344.
